fmap_stream_tx: RTL and testbench

- Reader/consumer side of the flattened feature-map array that conv2d produces.
- After `start`, walks `feature_flat` in flat index order (channel-major, then row, then col) and serialises each signed word into a byte stream with valid/ready handshake, MSB byte first.
- Optionally prefixes a 2-byte sync header.
- Sits between the conv/pool layers and the UART TX / host debug path, so feature maps can be dumped off-chip.

---
 rtl/fmap_stream_tx_pkg.sv | 18 +
 rtl/fmap_stream_tx_if.sv | 23 ++
 rtl/fmap_stream_tx.sv | 122 ++++++++++++
 tb/tb_fmap_stream_tx.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_stream_tx_pkg.sv
// Shared types and constants for the feature-map byte streamer.
package fmap_stream_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        LOAD,
        SEND
    } fmap_tx_state_t;

    localparam logic [7:0] FMAP_SYNC0 = 8'hA5;
    localparam logic [7:0] FMAP_SYNC1 = 8'h5A;

    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/fmap_stream_tx_if.sv
// Byte stream with valid/ready handshake and end-of-frame marker.
interface fmap_stream_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );

endinterface

// File: rtl/fmap_stream_tx.sv
// Walks a flattened feature-map array and emits each word as a byte
// stream, MSB byte first, optionally preceded by a 2-byte sync header.
module fmap_stream_tx
    import fmap_stream_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int OUT_CHANNELS = 8,
    parameter int IMG_SIZE     = 28,
    parameter int SEND_HEADER  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic signed [DATA_WIDTH-1:0] feature_flat
        [0:OUT_CHANNELS*IMG_SIZE*IMG_SIZE-1],
    fmap_stream_tx_if.master tx,
    output logic busy,
    output logic done
);

    localparam int N_WORDS = OUT_CHANNELS * IMG_SIZE * IMG_SIZE;
    localparam int BPW     = bytes_per_word(DATA_WIDTH);
    localparam int WW      = BPW * 8;
    localparam int WIW     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int BIW     = (BPW > 1) ? $clog2(BPW) : 1;

    fmap_tx_state_t r_state;
    logic [WIW-1:0] r_word_idx;
    logic [BIW-1:0] r_byte_idx;
    logic [WW-1:0]  r_word;
    logic           r_busy;
    logic           r_done;

    logic               w_valid;
    logic               w_hs;
    logic               w_last_byte;
    logic               w_last_word;
    logic               w_hdr_last;
    logic [WIW-1:0]     w_next_idx;
    logic [0:BPW-1][7:0] w_bytes;
    logic [7:0]         w_data;

    // Element 0 of the packed view is the most significant byte.
    assign w_bytes     = r_word;
    assign w_valid     = (r_state == HEADER) || (r_state == SEND);
    assign w_hs        = w_valid && tx.tx_ready;
    assign w_last_byte = (r_byte_idx == BIW'(BPW - 1));
    assign w_last_word = (r_word_idx == WIW'(N_WORDS - 1));
    assign w_hdr_last  = (r_byte_idx == BIW'(1));
    assign w_next_idx  = r_word_idx + WIW'(1);

    always_comb begin
        w_data = 8'h00;
        case (r_state)
            HEADER:  w_data = w_hdr_last ? FMAP_SYNC1 : FMAP_SYNC0;
            SEND:    w_data = w_bytes[r_byte_idx];
            default: w_data = 8'h00;
        endcase
    end

    assign tx.tx_valid = w_valid;
    assign tx.tx_data  = w_data;
    assign tx.tx_last  = (r_state == SEND) && w_last_word && w_last_byte;
    assign busy        = r_busy;
    assign done        = r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !r_done) begin
                        r_word_idx <= '0;
                        r_byte_idx <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= (SEND_HEADER != 0) ? HEADER : LOAD;
                    end
                end
                HEADER: begin
                    if (w_hs) begin
                        if (w_hdr_last) begin
                            r_byte_idx <= '0;
                            r_state    <= LOAD;
                        end else begin
                            r_byte_idx <= BIW'(1);
                        end
                    end
                end
                LOAD: begin
                    r_word     <= WW'(feature_flat[0]);
                    r_byte_idx <= '0;
                    r_state    <= SEND;
                end
                SEND: begin
                    if (w_hs) begin
                        if (!w_last_byte) begin
                            r_byte_idx <= r_byte_idx + BIW'(1);
                        end else if (!w_last_word) begin
                            r_word_idx <= w_next_idx;
                            r_word     <= WW'(feature_flat[w_next_idx]);
                            r_byte_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Bench for fmap_stream_tx: reference byte queues built from the array
// contents, checked cycle by cycle plus literal expected sequences.
module tb_fmap_stream_tx;

    localparam int NA = 4;
    localparam int NC = 8 * 28 * 28;

    typedef struct {
        logic [7:0] b;
        bit         last;
        bit         gap;
    } byte_t;
    typedef byte_t byte_q_t[$];

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b, start_c;
    logic busy_a, done_a, busy_b, done_b, busy_c, done_c;
    logic signed [15:0] feat_a [0:NA-1];
    logic signed [11:0] feat_b [0:NA-1];
    logic signed [15:0] feat_c [0:NC-1];

    fmap_stream_tx_if if_a ();
    fmap_stream_tx_if if_b ();
    fmap_stream_tx_if if_c ();

    always #5 clk = ~clk;

    fmap_stream_tx #(
        .DATA_WIDTH(16), .OUT_CHANNELS(1), .IMG_SIZE(2), .SEND_HEADER(1)
    ) ua (
        .clk(clk), .reset(reset), .start(start_a), .feature_flat(feat_a),
        .tx(if_a.master), .busy(busy_a), .done(done_a)
    );

    fmap_stream_tx #(
        .DATA_WIDTH(12), .OUT_CHANNELS(1), .IMG_SIZE(2), .SEND_HEADER(0)
    ) ub (
        .clk(clk), .reset(reset), .start(start_b), .feature_flat(feat_b),
        .tx(if_b.master), .busy(busy_b), .done(done_b)
    );

    fmap_stream_tx uc (
        .clk(clk), .reset(reset), .start(start_c), .feature_flat(feat_c),
        .tx(if_c.master), .busy(busy_c), .done(done_c)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Expected byte stream from the array values: header, then each value
    // split into big-endian bytes of its sign-extended form.
    function automatic byte_q_t frame(input int vals[$], input int dw,
                                      input bit hdr);
        byte_q_t q;
        byte_t e;
        int bpw;
        bpw = (dw + 7) / 8;
        if (hdr) begin
            e = '{8'hA5, 1'b0, 1'b0};
            q.push_back(e);
            e = '{8'h5A, 1'b0, 1'b1};
            q.push_back(e);
        end
        foreach (vals[i]) begin
            for (int k = 0; k < bpw; k++) begin
                e.b = 8'((vals[i] >>> (8 * (bpw - 1 - k))) & 255);
                e.last = (i == vals.size() - 1) && (k == bpw - 1);
                e.gap = 1'b0;
                q.push_back(e);
            end
        end
        return q;
    endfunction

    // ---- ready driver for DUT A
    int rdy_mode = 0;
    int rcnt = 0;
    always @(posedge clk) begin
        #2;
        rcnt++;
        case (rdy_mode)
            0: if_a.tx_ready = 1'b1;
            1: if_a.tx_ready = (rcnt % 3 == 0);
            default: if_a.tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---- per-cycle compare for DUT A
    byte_q_t qa;
    logic [7:0] got_a[$];
    bit pend_a = 0, gap_a = 0, stall_a = 0;
    logic [7:0] hd_a;
    logic hl_a;
    int dones_a = 0;

    always @(negedge clk) begin
        bit expv;
        if (!reset) begin
            chk("done_a", done_a, pend_a);
            if (done_a) dones_a++;
            pend_a = 0;
            chk("busy_a", busy_a, qa.size() != 0);
            expv = (qa.size() != 0) && !gap_a;
            gap_a = 0;
            chk("valid_a", if_a.tx_valid, expv);
            if (stall_a) begin
                chk("hold_data_a", if_a.tx_data, hd_a);
                chk("hold_last_a", if_a.tx_last, hl_a);
            end
            stall_a = 0;
            if (if_a.tx_valid && expv) begin
                chk("data_a", if_a.tx_data, qa[0].b);
                chk("last_a", if_a.tx_last, qa[0].last);
                if (if_a.tx_ready) begin
                    got_a.push_back(if_a.tx_data);
                    gap_a = qa[0].gap;
                    pend_a = qa[0].last;
                    void'(qa.pop_front());
                end else begin
                    stall_a = 1;
                    hd_a = if_a.tx_data;
                    hl_a = if_a.tx_last;
                end
            end else begin
                chk("nolast_a", if_a.tx_last, 0);
            end
        end
    end

    // ---- capture for DUTs B and C
    logic [7:0] got_b[$], got_c[$];
    int fv_b = -1, last_b = -1;
    int last_c = -1, nlast_c = 0, dc_c = -1;

    always @(negedge clk) begin
        if (!reset) begin
            if (if_b.tx_valid && fv_b < 0) fv_b = cyc;
            if (if_b.tx_valid && if_b.tx_ready) begin
                if (if_b.tx_last) last_b = got_b.size();
                got_b.push_back(if_b.tx_data);
            end
            if (if_c.tx_valid && if_c.tx_ready) begin
                if (if_c.tx_last) begin
                    last_c = got_c.size();
                    nlast_c++;
                end
                got_c.push_back(if_c.tx_data);
            end
            if (done_c && dc_c < 0) dc_c = cyc;
        end
    end

    task automatic load_a();
        int v[$];
        foreach (feat_a[i]) v.push_back(int'(feat_a[i]));
        qa = frame(v, 16, 1'b1);
    endtask

    task automatic run_a(input bit ign);
        int d0, n0;
        d0 = dones_a;
        n0 = got_a.size();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        load_a();
        if (ign) begin
            repeat (3) @(negedge clk);
            start_a = 1'b1;
            @(posedge clk);
            #1 start_a = 1'b0;
        end
        for (int i = 0; i < 500 && dones_a == d0; i++) begin
            @(negedge clk);
            #1;
        end
        if (ign) begin
            start_a = 1'b1;
            @(posedge clk);
            #1 start_a = 1'b0;
        end
        repeat (4) @(negedge clk);
        #1;
        chk("frame_done_a", dones_a - d0, 1);
        chk("frame_len_a", got_a.size() - n0, 10);
    endtask

    logic [7:0] lit_a [10] = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'hFF,
                               8'hFE, 8'h00, 8'h7F, 8'h80, 8'h00};
    logic [7:0] lit_b [8] = '{8'hFF, 8'hFF, 8'h07, 8'hFF,
                              8'hF8, 8'h00, 8'h00, 8'h05};

    initial begin
        int n0, cs;
        byte_q_t exp_c;
        int v[$];
        reset = 1'b1;
        start_a = 0;
        start_b = 0;
        start_c = 0;
        if_b.tx_ready = 1'b1;
        if_c.tx_ready = 1'b1;
        foreach (feat_a[i]) feat_a[i] = '0;
        foreach (feat_b[i]) feat_b[i] = '0;
        foreach (feat_c[i]) feat_c[i] = '0;
        #1;
        chk("rst_valid_a", if_a.tx_valid, 0);
        chk("rst_data_a", if_a.tx_data, 0);
        chk("rst_last_a", if_a.tx_last, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_valid_c", if_c.tx_valid, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        // fixed words, ready held high
        feat_a = '{16'h1234, 16'hFFFE, 16'h007F, 16'h8000};
        rdy_mode = 0;
        n0 = got_a.size();
        run_a(1'b0);
        for (int k = 0; k < 10; k++)
            chk($sformatf("seq_a[%0d]", k), got_a[n0 + k], lit_a[k]);

        // same words, ready 1,0,0 pattern
        rdy_mode = 1;
        n0 = got_a.size();
        run_a(1'b0);
        for (int k = 0; k < 10; k++)
            chk($sformatf("stall_seq_a[%0d]", k), got_a[n0 + k], lit_a[k]);

        // extra starts mid-frame and on the done cycle
        rdy_mode = 0;
        run_a(1'b1);

        // reset between byte 4 and byte 5
        n0 = got_a.size();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        load_a();
        for (int i = 0; i < 50 && got_a.size() < n0 + 4; i++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort_valid_a", if_a.tx_valid, 0);
        chk("abort_busy_a", busy_a, 0);
        chk("abort_done_a", done_a, 0);
        chk("abort_last_a", if_a.tx_last, 0);
        qa.delete();
        pend_a = 0;
        gap_a = 0;
        stall_a = 0;
        @(posedge clk);
        #3 reset = 1'b0;
        n0 = got_a.size();
        run_a(1'b0);
        chk("restart_first_a", got_a[n0], 8'hA5);
        chk("restart_third_a", got_a[n0 + 2], 8'h12);

        // random words, random ready
        rdy_mode = 2;
        repeat (6) begin
            foreach (feat_a[i]) feat_a[i] = 16'($urandom);
            run_a(1'b0);
        end
        rdy_mode = 0;

        // 12-bit words, no header
        feat_b = '{12'hFFF, 12'h7FF, 12'h800, 12'h005};
        fv_b = -1;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        cs = cyc;
        for (int i = 0; i < 100 && !done_b; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("b_first_valid_lat", fv_b + 1 - cs, 2);
        chk("b_len", got_b.size(), 8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("seq_b[%0d]", k), got_b[k], lit_b[k]);
        chk("b_last_pos", last_b, 7);
        chk("b_busy_after", busy_b, 0);

        // default geometry, random contents
        foreach (feat_c[i]) feat_c[i] = 16'($urandom);
        foreach (feat_c[i]) v.push_back(int'(feat_c[i]));
        exp_c = frame(v, 16, 1'b1);
        @(negedge clk);
        start_c = 1'b1;
        @(posedge clk);
        #1 start_c = 1'b0;
        cs = cyc;
        for (int i = 0; i < 13000 && dc_c < 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("c_done_lat", dc_c + 1 - cs, 12548);
        chk("c_len", got_c.size(), 12546);
        chk("c_last_pos", last_c, 12545);
        chk("c_last_cnt", nlast_c, 1);
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++)
            chk($sformatf("c_byte%0d", i), got_c[i], exp_c[i].b);
        @(negedge clk);
        chk("c_busy_after", busy_c, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
